// File: rtl/s_term_pkg.sv
// Shared constants for the south-terminal tile: loopback mode encoding and
// the mode the tile falls back to on reset.
package s_term_pkg;

    localparam int CFG_W = 2;

    typedef enum logic [CFG_W-1:0] {
        MODE_PASS = 2'b00,
        MODE_REG  = 2'b01,
        MODE_INV  = 2'b10,
        MODE_OFF  = 2'b11
    } mode_e;

    localparam mode_e MODE_RESET = MODE_OFF;

endpackage

// File: rtl/s_term_frame_pipe.sv
// WIDTH x DEPTH retiming shift pipeline with synchronous reset; DEPTH=0
// degenerates to a plain wire.
module s_term_frame_pipe #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_ctrl;
            assign unused_ctrl = clk ^ rst;
            assign dout = din;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage_p [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) stage_p[i] <= '0;
                end else begin
                    stage_p[0] <= din;
                    for (int i = 1; i < DEPTH; i++) stage_p[i] <= stage_p[i-1];
                end
            end

            assign dout = stage_p[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/s_term_cfg_pipe.sv
// South-terminal tile: configurable north loopback of south-arriving wires,
// retimed frame-bus forwarding, and a sticky multi-strobe error flag.
module s_term_cfg_pipe
    import s_term_pkg::*;
#(
    parameter int FrameBitsPerRow = 32,
    parameter int MaxFramesPerCol = 20,
    parameter int PIPE_STAGES     = 1,
    parameter int LOOP_W          = 52,
    parameter int CFG_FRAME       = 0
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [LOOP_W-1:0]          S_IN,
    output logic [LOOP_W-1:0]          N_OUT,
    input  logic [FrameBitsPerRow-1:0] FrameData,
    output logic [FrameBitsPerRow-1:0] FrameData_O,
    input  logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic [MaxFramesPerCol-1:0] FrameStrobe_O,
    output logic [CFG_W-1:0]           CfgMode,
    output logic                       FrameErr
);

    localparam logic [MaxFramesPerCol-1:0] STROBE_ONE = MaxFramesPerCol'(1);

    mode_e             cfg;
    logic              multi_strobe;
    logic              cfg_load;
    logic              frame_err;
    logic [LOOP_W-1:0] loop_p0;
    logic              unused_frame_bits;

    assign unused_frame_bits = ^FrameData[FrameBitsPerRow-1:CFG_W];

    // Clearing the lowest set bit leaves something behind only if >1 bit was set.
    assign multi_strobe = (FrameStrobe & (FrameStrobe - STROBE_ONE)) != '0;
    assign cfg_load     = FrameStrobe[CFG_FRAME] && !multi_strobe;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cfg       <= MODE_RESET;
            frame_err <= 1'b0;
        end else begin
            if (cfg_load) cfg <= mode_e'(FrameData[CFG_W-1:0]);
            if (multi_strobe) frame_err <= 1'b1;
        end
    end

    // Loop register runs every cycle so REG mode starts from last cycle's S_IN.
    always_ff @(posedge CLK) begin
        if (RESET) loop_p0 <= '0;
        else       loop_p0 <= S_IN;
    end

    always_comb begin
        N_OUT = '0;
        unique case (cfg)
            MODE_PASS: N_OUT = S_IN;
            MODE_REG:  N_OUT = loop_p0;
            MODE_INV:  N_OUT = ~S_IN;
            MODE_OFF:  N_OUT = '0;
            default:   N_OUT = '0;
        endcase
    end

    assign CfgMode  = cfg;
    assign FrameErr = frame_err;

    s_term_frame_pipe #(
        .WIDTH (FrameBitsPerRow),
        .DEPTH (PIPE_STAGES)
    ) u_data_pipe (
        .clk  (CLK),
        .rst  (RESET),
        .din  (FrameData),
        .dout (FrameData_O)
    );

    s_term_frame_pipe #(
        .WIDTH (MaxFramesPerCol),
        .DEPTH (PIPE_STAGES)
    ) u_strobe_pipe (
        .clk  (CLK),
        .rst  (RESET),
        .din  (FrameStrobe),
        .dout (FrameStrobe_O)
    );

endmodule

// File: tb/tb_s_term_cfg_pipe.sv
// Directed bench for s_term_cfg_pipe with a two-stage frame pipeline.
module tb_s_term_cfg_pipe;

    localparam int FB = 32;
    localparam int MF = 20;
    localparam int PS = 2;
    localparam int LW = 52;

    logic          clk = 1'b0;
    logic          rst;
    logic [LW-1:0] s_in;
    logic [LW-1:0] n_out;
    logic [FB-1:0] fdata;
    logic [FB-1:0] fdata_o;
    logic [MF-1:0] fstrobe;
    logic [MF-1:0] fstrobe_o;
    logic [1:0]    cfg_mode;
    logic          ferr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    s_term_cfg_pipe #(
        .FrameBitsPerRow (FB),
        .MaxFramesPerCol (MF),
        .PIPE_STAGES     (PS),
        .LOOP_W          (LW),
        .CFG_FRAME       (0)
    ) dut (
        .CLK           (clk),
        .RESET         (rst),
        .S_IN          (s_in),
        .N_OUT         (n_out),
        .FrameData     (fdata),
        .FrameData_O   (fdata_o),
        .FrameStrobe   (fstrobe),
        .FrameStrobe_O (fstrobe_o),
        .CfgMode       (cfg_mode),
        .FrameErr      (ferr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [FB-1:0] seq_d [6];
    logic [MF-1:0] seq_s [6];

    initial begin
        seq_d = '{32'h1, 32'h2, 32'h3, 32'h0, 32'h0, 32'h0};
        seq_s = '{20'h00008, 20'h00010, 20'h00020, 20'h0, 20'h0, 20'h0};

        rst = 1'b1; s_in = '0; fdata = '0; fstrobe = '0;
        tick(); tick();

        // Reset state, pipeline shows zeros while inputs are nonzero
        rst = 1'b0; fdata = 32'hDEADBEEF; fstrobe = 20'h00008; s_in = 52'hA5A5A5A5A5A5A;
        #1;
        check("rst_nout", n_out, 0);
        check("rst_cfg", cfg_mode, 2'b11);
        check("rst_err", ferr, 0);
        check("rst_fdo", fdata_o, 0);
        check("rst_fso", fstrobe_o, 0);
        tick();
        fdata = '0; fstrobe = '0;
        check("lat1_fso", fstrobe_o, 0);
        check("lat1_fdo", fdata_o, 0);
        tick();
        check("lat2_fdo", fdata_o, 32'hDEADBEEF);
        check("lat2_fso", fstrobe_o, 20'h00008);
        check("nocfg_bit3", cfg_mode, 2'b11);

        // REG mode: 1-cycle lag
        fdata = 32'h1; fstrobe = 20'h00001;
        tick();
        check("reg_cfg", cfg_mode, 2'b01);
        check("reg_first", n_out, 52'hA5A5A5A5A5A5A);
        fstrobe = '0; fdata = '0; s_in = 52'h123456789ABCD;
        #1;
        check("reg_hold", n_out, 52'hA5A5A5A5A5A5A);
        tick();
        check("reg_next", n_out, 52'h123456789ABCD);

        // PASS then INV, combinational
        fdata = 32'h0; fstrobe = 20'h00001;
        tick();
        fstrobe = '0; s_in = 52'h0F0F0F0F0F0F0;
        #1;
        check("pass_cfg", cfg_mode, 2'b00);
        check("pass_nout", n_out, 52'h0F0F0F0F0F0F0);
        fdata = 32'h2; fstrobe = 20'h00001;
        tick();
        fstrobe = '0; fdata = '0;
        #1;
        check("inv_cfg", cfg_mode, 2'b10);
        check("inv_nout", n_out, 52'hF0F0F0F0F0F0F);
        s_in = 52'h0000000000001;
        #1;
        check("inv_comb", n_out, 52'hFFFFFFFFFFFFE);

        // Upper FrameData bits ignored: 0xFFFFFFFF loads OFF
        fdata = 32'hFFFFFFFF; fstrobe = 20'h00001;
        tick();
        fdata = '0; fstrobe = '0;
        #1;
        check("off_cfg", cfg_mode, 2'b11);
        check("off_nout", n_out, 0);

        // Aligned frame sequence, two cycles late
        for (int i = 0; i < 6; i++) begin
            fdata = seq_d[i]; fstrobe = seq_s[i];
            tick();
            if (i >= 1) begin
                check($sformatf("seq_d%0d", i), fdata_o, seq_d[i-1]);
                check($sformatf("seq_s%0d", i), fstrobe_o, seq_s[i-1]);
            end
        end
        check("seq_cfg", cfg_mode, 2'b11);

        // Multi-strobe: error sticky, cfg load suppressed, strobes forwarded
        fdata = 32'h0; fstrobe = 20'h00011;
        tick();
        fstrobe = '0;
        check("err_set", ferr, 1);
        check("err_cfg", cfg_mode, 2'b11);
        tick();
        check("err_fso", fstrobe_o, 20'h00011);
        check("err_sticky1", ferr, 1);
        tick();
        check("err_sticky2", ferr, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("err_clr", ferr, 0);

        // Back-to-back config loads, last wins
        fdata = 32'h2; fstrobe = 20'h00001;
        tick();
        check("b2b_first", cfg_mode, 2'b10);
        fdata = 32'h0;
        tick();
        fstrobe = '0;
        check("b2b_last", cfg_mode, 2'b00);

        // Reset beats a same-cycle config load and flushes frames in flight
        fdata = 32'hAAAA5555; fstrobe = 20'h00020;
        tick();
        rst = 1'b1; fdata = 32'h1; fstrobe = 20'h00001;
        tick();
        check("rstld_cfg", cfg_mode, 2'b11);
        check("rstld_nout", n_out, 0);
        check("rstld_fdo", fdata_o, 0);
        check("rstld_fso", fstrobe_o, 0);
        rst = 1'b0; fdata = '0; fstrobe = '0;
        tick();
        check("flush_fdo", fdata_o, 0);
        check("flush_fso", fstrobe_o, 0);
        check("flush_cfg", cfg_mode, 2'b11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
